pipe_hazard_ctl: RTL and testbench

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/cpu_pkg.sv | 14 +
 rtl/hazard_match.sv | 30 +++
 rtl/pipe_hazard_ctl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: operand-forward select encodings and pipeline position numbering.
package cpu_pkg;

  localparam int FW_RF   = 0;
  localparam int POS_EX  = 1;
  localparam int POS_MEM = 2;
  localparam int POS_WB  = 3;

  // Forward select seen by EX next cycle for a producer now at position p.
  function automatic int fwd_code(input int p, input int depth);
    return (p + 1 <= depth) ? p + 1 : FW_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Match/ready logic for one in-flight table position against one ID source register.
module hazard_match
  import cpu_pkg::*;
#(
  parameter int RW       = 5,
  parameter int DEPTH    = POS_WB,
  parameter int LOAD_LAT = 1,
  parameter int P        = POS_EX,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic [RW-1:0] src,
  input  logic          use_src,
  input  logic          ent_valid,
  input  logic [RW-1:0] ent_reg,
  input  logic          ent_load,
  output logic          hit,
  output logic          ready,
  output logic [FW-1:0] sel
);

  // Past DEPTH the value is already in the write-through register file, so never a hazard.
  localparam bit IN_RANGE = (P + 1 <= DEPTH);
  localparam bit ALU_OK   = (P + 1 >= POS_MEM);
  localparam bit LOAD_OK  = (P + 1 >= POS_MEM + LOAD_LAT);

  assign hit   = use_src & ent_valid & (src != '0) & (ent_reg == src);
  assign ready = !IN_RANGE || (ent_load ? LOAD_OK : ALU_OK);
  assign sel   = FW'(fwd_code(P, DEPTH));

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use stall, operand forwarding select, redirect squash.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module pipe_hazard_ctl
  import cpu_pkg::*;
#(
  parameter int RW       = 5,
  parameter int DEPTH    = POS_WB,
  parameter int LOAD_LAT = 1,
  parameter int BR_POS   = POS_MEM,
  localparam int FW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wr_en,
  input  logic [RW-1:0] id_wr_reg,
  input  logic          id_is_load,
  input  logic          redirect,
  output logic          stall,
  output logic          issue,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_flush
);

  logic [DEPTH:1] ent_valid;
  logic [DEPTH:1] ent_load;
  logic [RW-1:0]  ent_reg [1:DEPTH];

  logic [DEPTH:1] hit_a, rdy_a, hit_b, rdy_b;
  logic [FW-1:0]  sel_a [1:DEPTH];
  logic [FW-1:0]  sel_b [1:DEPTH];

  for (genvar p = POS_EX; p <= DEPTH; p++) begin : g_pos
    hazard_match #(.RW(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .P(p)) u_match_a (
      .src(id_rs), .use_src(id_use_rs), .ent_valid(ent_valid[p]), .ent_reg(ent_reg[p]),
      .ent_load(ent_load[p]), .hit(hit_a[p]), .ready(rdy_a[p]), .sel(sel_a[p])
    );
    hazard_match #(.RW(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .P(p)) u_match_b (
      .src(id_rt), .use_src(id_use_rt), .ent_valid(ent_valid[p]), .ent_reg(ent_reg[p]),
      .ent_load(ent_load[p]), .hit(hit_b[p]), .ready(rdy_b[p]), .sel(sel_b[p])
    );
  end

  logic [FW-1:0] pick_a, pick_b;
  logic          blocked_a, blocked_b;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    pick_a    = FW'(FW_RF);
    pick_b    = FW'(FW_RF);
    blocked_a = 1'b0;
    blocked_b = 1'b0;
    for (int p = DEPTH; p >= POS_EX; p--) begin
      if (hit_a[p]) begin
        pick_a    = sel_a[p];
        blocked_a = !rdy_a[p];
      end
      if (hit_b[p]) begin
        pick_b    = sel_b[p];
        blocked_b = !rdy_b[p];
      end
    end
  end

  // ID->EX handshake: id_valid is valid, ~stall is ready, issue is the transfer;
  // redirect squashes the ID instruction and overrides any stall.
  assign stall = id_valid & (blocked_a | blocked_b) & ~redirect;
  assign issue = id_valid & ~stall & ~redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_load  <= '0;
      for (int p = POS_EX; p <= DEPTH; p++) ent_reg[p] <= '0;
      fwd_a <= FW'(FW_RF);
      fwd_b <= FW'(FW_RF);
    end else begin
      ent_valid[POS_EX] <= issue & id_wr_en & (id_wr_reg != '0);
      ent_reg[POS_EX]   <= id_wr_reg;
      ent_load[POS_EX]  <= id_is_load;
      // Instructions younger than the resolving branch are dropped as they shift.
      for (int p = POS_EX + 1; p <= DEPTH; p++) begin
        ent_valid[p] <= ent_valid[p-1] & ~(redirect && (p - 1 < BR_POS));
        ent_reg[p]   <= ent_reg[p-1];
        ent_load[p]  <= ent_load[p-1];
      end
      fwd_a <= issue ? pick_a : FW'(FW_RF);
      fwd_b <= issue ? pick_b : FW'(FW_RF);
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      if (redirect && (perf_flush != '1)) perf_flush <= perf_flush + 32'd1;
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: directed hazard cases plus random ID traffic,
// checked by a scoreboard fed from an issue-history reference model.
module tb_pipe_hazard_ctl;

  localparam int RW       = 5;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int BR_POS   = 2;
  localparam int FW       = $clog2(DEPTH + 1);
  localparam int EW       = 2 + 2 * FW + 64;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [RW-1:0] id_rs, id_rt, id_wr_reg;
  logic          id_use_rs, id_use_rt, id_wr_en, id_is_load;
  logic          redirect;
  logic          stall, issue;
  logic [FW-1:0] fwd_a, fwd_b;
  logic [31:0]   perf_stall, perf_flush;

  pipe_hazard_ctl #(.RW(RW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .BR_POS(BR_POS)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .redirect(redirect),
    .stall(stall), .issue(issue), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            rst;
    bit            valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    bit            use_rs;
    bit            use_rt;
    bit            wr_en;
    logic [RW-1:0] wr_reg;
    bit            is_load;
    bit            redir;
  } op_t;

  // One record per issued register-writing instruction; position = cycle - issue cycle.
  typedef struct {
    int            c;
    logic [RW-1:0] rg;
    bit            ld;
    bit            dead;
  } hist_t;

  hist_t         hist[$];
  logic [EW-1:0] exp_q[$];
  int            cyc;
  int            n_tests;
  int            n_fail;
  logic [FW-1:0] nxt_a, nxt_b;
  logic [31:0]   cnt_stall, cnt_flush;
  bit            last_stall;

  // ---------------- reference model ----------------
  function automatic void lookup(input logic [RW-1:0] r, input bit use_r,
                                 output int sel, output bit haz);
    int best;
    bit ld;
    sel  = 0;
    haz  = 1'b0;
    best = DEPTH + 1;
    ld   = 1'b0;
    if (!use_r || r == '0) return;
    foreach (hist[i]) begin
      int p;
      p = cyc - hist[i].c;
      if (!hist[i].dead && p >= 1 && p <= DEPTH && hist[i].rg == r && p < best) begin
        best = p;
        ld   = hist[i].ld;
      end
    end
    if (best > DEPTH) return;
    if (best + 1 > DEPTH) return;
    if (best + 1 < (ld ? 2 + LOAD_LAT : 2)) haz = 1'b1;
    else sel = best + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input op_t op);
    int sa, sb;
    bit ha, hb, exp_stall, exp_issue;
    logic [FW-1:0] ea, eb;
    logic [31:0] ps, pf;
    @(posedge clk);
    #1;
    rst_n      = ~op.rst;
    id_valid   = op.valid;
    id_rs      = op.rs;
    id_rt      = op.rt;
    id_use_rs  = op.use_rs;
    id_use_rt  = op.use_rt;
    id_wr_en   = op.wr_en;
    id_wr_reg  = op.wr_reg;
    id_is_load = op.is_load;
    redirect   = op.redir;
    if (op.rst) begin
      hist.delete();
      nxt_a     = '0;
      nxt_b     = '0;
      cnt_stall = '0;
      cnt_flush = '0;
    end
    ea = nxt_a;
    eb = nxt_b;
`ifdef HAZARD_PERF_EN
    ps = cnt_stall;
    pf = cnt_flush;
`else
    ps = '0;
    pf = '0;
`endif
    lookup(op.rs, op.use_rs, sa, ha);
    lookup(op.rt, op.use_rt, sb, hb);
    exp_stall = op.valid & (ha | hb) & ~op.redir;
    exp_issue = op.valid & ~exp_stall & ~op.redir;
    exp_q.push_back({exp_stall, exp_issue, ea, eb, ps, pf});
    last_stall = exp_stall;
    if (!op.rst) begin
      if (exp_stall && cnt_stall != 32'hFFFFFFFF) cnt_stall++;
      if (op.redir && cnt_flush != 32'hFFFFFFFF) cnt_flush++;
      if (op.redir)
        foreach (hist[i])
          if (cyc - hist[i].c >= 1 && cyc - hist[i].c < BR_POS) hist[i].dead = 1'b1;
      if (exp_issue && op.wr_en && op.wr_reg != '0)
        hist.push_back('{cyc, op.wr_reg, op.is_load, 1'b0});
      nxt_a = exp_issue ? FW'(sa) : '0;
      nxt_b = exp_issue ? FW'(sb) : '0;
    end else begin
      nxt_a = '0;
      nxt_b = '0;
    end
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].c > DEPTH) void'(hist.pop_front());
  endtask

  function automatic op_t mk(input bit valid, input int rs, input int rt, input bit urs,
                             input bit urt, input bit wr, input int wrr, input bit ld,
                             input bit redir, input bit rst);
    op_t o;
    o.rst = rst; o.valid = valid; o.rs = RW'(rs); o.rt = RW'(rt);
    o.use_rs = urs; o.use_rt = urt; o.wr_en = wr; o.wr_reg = RW'(wrr);
    o.is_load = ld; o.redir = redir;
    return o;
  endfunction

  task automatic now_chk(input string name, input bit st, input bit is);
    #2;
    check({name, "_stall"}, 32'(stall), 32'(st));
    check({name, "_issue"}, 32'(issue), 32'(is));
  endtask

  task automatic fwd_chk(input string name, input int a, input int b);
    #2;
    check({name, "_fwd_a"}, 32'(fwd_a), 32'(a));
    check({name, "_fwd_b"}, 32'(fwd_b), 32'(b));
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall",      32'(stall),  32'(e[65+2*FW]));
        check("issue",      32'(issue),  32'(e[64+2*FW]));
        check("fwd_a",      32'(fwd_a),  32'(e[64+FW +: FW]));
        check("fwd_b",      32'(fwd_b),  32'(e[64 +: FW]));
        check("perf_stall", perf_stall,  e[63:32]);
        check("perf_flush", perf_flush,  e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    op_t nop, cur;
    n_tests = 0; n_fail = 0; cyc = 0;
    nxt_a = '0; nxt_b = '0; cnt_stall = '0; cnt_flush = '0; last_stall = 1'b0;
    rst_n = 1'b0; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0;
    id_use_rt = 1'b0; id_wr_en = 1'b0; id_wr_reg = '0; id_is_load = 1'b0; redirect = 1'b0;
    nop = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    do_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    fwd_chk("reset", 0, 0);
    check("reset_perf_stall", perf_stall, 32'd0);
    drain();

    // add r3 ; add r4,r3,r5
    do_cycle(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0));
    do_cycle(mk(1, 3, 5, 1, 1, 1, 4, 0, 0, 0));
    now_chk("alu_fwd", 0, 1);
    do_cycle(nop);
    fwd_chk("alu_fwd", 2, 0);
    drain();

    // lw r1 ; add r2,r1,r1 : one bubble then forward from WB
    do_cycle(mk(1, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0));
    now_chk("load_use_1", 1, 0);
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0));
    now_chk("load_use_2", 0, 1);
    fwd_chk("load_use_bubble", 0, 0);
    do_cycle(nop);
    fwd_chk("load_use", 3, 3);
    drain();

    // lw r1 ; nop ; add r2,r1,r0
    do_cycle(mk(1, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    do_cycle(nop);
    do_cycle(mk(1, 1, 0, 1, 1, 1, 2, 0, 0, 0));
    now_chk("load_gap", 0, 1);
    do_cycle(nop);
    fwd_chk("load_gap", 3, 0);
    drain();

    // lw r0 ; add r2,r0,r0
    do_cycle(mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    do_cycle(mk(1, 0, 0, 1, 1, 1, 2, 0, 0, 0));
    now_chk("r0", 0, 1);
    do_cycle(nop);
    fwd_chk("r0", 0, 0);
    drain();

    // lw r1 ; add r2,r1,r1 with redirect : lw is squashed
    do_cycle(mk(1, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 1, 0));
    now_chk("redirect", 0, 0);
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0));
    now_chk("after_redirect", 0, 1);
    do_cycle(nop);
    fwd_chk("after_redirect", 0, 0);
    drain();

    // reset during a load-use stall
    do_cycle(mk(1, 0, 0, 1, 0, 1, 1, 1, 0, 0));
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0));
    now_chk("pre_reset", 1, 0);
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 1));
    now_chk("in_reset", 0, 1);
    check("in_reset_perf_stall", perf_stall, 32'd0);
    do_cycle(mk(1, 1, 1, 1, 1, 1, 2, 0, 0, 0));
    now_chk("post_reset", 0, 1);
    do_cycle(nop);
    fwd_chk("post_reset", 0, 0);
    drain();

    // random traffic; a stalled instruction is held in ID until it issues
    cur = nop;
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) begin
        cur.valid   = ($urandom_range(0, 99) < 85);
        cur.rs      = RW'($urandom_range(0, 3));
        cur.rt      = RW'($urandom_range(0, 3));
        cur.use_rs  = $urandom_range(0, 1);
        cur.use_rt  = $urandom_range(0, 1);
        cur.wr_en   = ($urandom_range(0, 9) < 7);
        cur.wr_reg  = RW'($urandom_range(0, 3));
        cur.is_load = ($urandom_range(0, 9) < 4);
      end
      cur.redir = ($urandom_range(0, 99) < 8);
      cur.rst   = ($urandom_range(0, 199) == 0);
      do_cycle(cur);
    end
    drain();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: actual=%0d pending expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
